// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: bubble encoding, word size and fetch FSM states.
package pipe_pkg;
    localparam logic [31:0] NOP_INSTR_C = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES  = 32'd4;

    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} fetch_state_e;

    function automatic logic [31:0] next_word(input logic [31:0] a);
        return a + WORD_BYTES;
    endfunction
endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/valid handshake; fetch stage is the master.
interface if_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;

    modport master (output imem_req, imem_addr, input imem_rdata, imem_valid);
    modport slave  (input imem_req, imem_addr, output imem_rdata, imem_valid);
endinterface

// File: rtl/if_fetch_stage_if2id.sv
// IF/ID pipeline register: bubble beats load, otherwise contents hold.
module IF2ID
    import pipe_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] instr_in,
    input  logic [31:0] next_in,
    output logic [31:0] Instruction,
    output logic [31:0] Next_Address,
    output logic        if_valid
);
    logic [31:0] instr_q, instr_d, next_q, next_d;
    logic        valid_q, valid_d;

    always_comb begin
        instr_d = instr_q;
        next_d  = next_q;
        valid_d = valid_q;
        if (bubble) begin
            instr_d = NOP_INSTR;
            next_d  = 32'h0;
            valid_d = 1'b0;
        end else if (load) begin
            instr_d = instr_in;
            next_d  = next_in;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            instr_q <= NOP_INSTR;
            next_q  <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            next_q  <= next_d;
            valid_q <= valid_d;
        end
    end

    assign Instruction  = instr_q;
    assign Next_Address = next_q;
    assign if_valid     = valid_q;
endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem handshake, IF/ID register.
// Define IF_MISALIGN_CHK_EN to align redirect targets and flag misaligned ones.
module if_fetch_stage
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     PCWrite,
    input  logic                     freeze,
    input  logic                     PCSrc,
    input  logic [31:0]              Branch_Address,
    input  logic                     flush,
    if_fetch_stage_if.master         imem,
    output logic [31:0]              Instruction,
    output logic [31:0]              Next_Address,
    output logic                     if_valid,
    output logic                     fetch_err
);
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d, req_addr_q, req_addr_d, hold_buf_q, hold_buf_d;
    logic [31:0]  tgt, seq_addr, ifid_instr, ifid_next;
    logic         stall, ifid_load, ifid_bubble;

    assign stall    = freeze | ~PCWrite;
    assign seq_addr = next_word(req_addr_q);

`ifdef IF_MISALIGN_CHK_EN
    logic err_q, err_d;
    assign tgt       = {Branch_Address[31:2], 2'b00};
    assign fetch_err = err_q;
    assign err_d     = err_q | (PCSrc & (|Branch_Address[1:0]));
`else
    assign tgt       = Branch_Address;
    assign fetch_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        hold_buf_d  = hold_buf_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        if (PCSrc) begin
            pc_d        = tgt;
            ifid_bubble = 1'b1;
            case (state_q)
                FETCH: begin
                    // A pending request must finish before the target can be issued.
                    if (imem.imem_valid) req_addr_d = tgt;
                    else                 state_d    = DRAIN;
                end
                HOLD: begin
                    req_addr_d = tgt;
                    state_d    = FETCH;
                end
                default: ;
            endcase
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem.imem_valid) begin
                        pc_d = seq_addr;
                        if (stall | flush) begin
                            hold_buf_d  = imem.imem_rdata;
                            ifid_bubble = flush;
                            state_d     = HOLD;
                        end else begin
                            ifid_load  = 1'b1;
                            req_addr_d = seq_addr;
                        end
                    end else if (flush | ~stall) begin
                        ifid_bubble = 1'b1;
                    end
                end
                HOLD: begin
                    if (flush) begin
                        ifid_bubble = 1'b1;
                    end else if (!stall) begin
                        ifid_load  = 1'b1;
                        req_addr_d = pc_q;
                        state_d    = FETCH;
                    end
                end
                default: begin
                    ifid_bubble = 1'b1;
                    if (imem.imem_valid) begin
                        req_addr_d = pc_q;
                        state_d    = FETCH;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            hold_buf_q <= 32'h0;
`ifdef IF_MISALIGN_CHK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            hold_buf_q <= hold_buf_d;
`ifdef IF_MISALIGN_CHK_EN
            err_q      <= err_d;
`endif
        end
    end

    assign imem.imem_req  = ((state_q == FETCH) | (state_q == DRAIN)) & rst;
    assign imem.imem_addr = req_addr_q;

    // In HOLD pc already points past the buffered word.
    assign ifid_instr = (state_q == HOLD) ? hold_buf_q : imem.imem_rdata;
    assign ifid_next  = (state_q == HOLD) ? pc_q : seq_addr;

    IF2ID #(.NOP_INSTR(NOP_INSTR)) u_if2id (
        .clk          (clk),
        .rst          (rst),
        .load         (ifid_load),
        .bubble       (ifid_bubble),
        .instr_in     (ifid_instr),
        .next_in      (ifid_next),
        .Instruction  (Instruction),
        .Next_Address (Next_Address),
        .if_valid     (if_valid)
    );
endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed table, DRAIN/misalign sequences, random vs model.
module tb_if_fetch_stage;
    localparam logic [31:0] RPC = 32'h100;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, PCWrite, freeze, PCSrc, flush;
    logic [31:0] Branch_Address, Instruction, Next_Address;
    logic        if_valid, fetch_err;
    int          tests = 0, fails = 0;

    if_fetch_stage_if mif();

    if_fetch_stage #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .PCWrite(PCWrite), .freeze(freeze), .PCSrc(PCSrc),
        .Branch_Address(Branch_Address), .flush(flush), .imem(mif),
        .Instruction(Instruction), .Next_Address(Next_Address),
        .if_valid(if_valid), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Memory: valid once the request has been up for mlat cycles.
    int mcnt = 0, mlat = 0, fixed_lat = 0;
    bit rand_lat = 1'b0;
    assign mif.imem_valid = mif.imem_req && (mcnt >= mlat);
    assign mif.imem_rdata = mem_word(mif.imem_addr);
    always @(posedge clk) begin
        if (mif.imem_req && mif.imem_valid) begin
            mcnt <= 0;
            mlat <= rand_lat ? int'($urandom_range(0, 2)) : fixed_lat;
        end else if (mif.imem_req) mcnt <= mcnt + 1;
        else mcnt <= 0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic pw, input logic fz, input logic src, input logic [31:0] ba, input logic fl);
        PCWrite = pw; freeze = fz; PCSrc = src; Branch_Address = ba; flush = fl;
    endtask

    typedef struct {
        logic        pw, fz, src, fl;
        logic [31:0] ba;
        logic        exp_req;
        logic [31:0] exp_addr, exp_next;
        logic        exp_vld;
    } vec_t;

    vec_t tbl[13];

    // Behavioural model state
    logic [31:0] m_addr, m_pc, e_instr, e_next, tgt;
    logic        e_vld, m_err, stale, e_req, v, r, st;
    logic [31:0] held_q[$];
    bit          found;
    logic [31:0] exp_tgt;
    logic        exp_err;

    initial begin
        tbl[0]  = '{1, 0, 0, 0, 0,            1, 32'h100, 32'h104, 1};
        tbl[1]  = '{1, 0, 0, 0, 0,            1, 32'h104, 32'h108, 1};
        tbl[2]  = '{1, 0, 0, 0, 0,            1, 32'h108, 32'h10C, 1};
        tbl[3]  = '{0, 1, 0, 0, 0,            1, 32'h10C, 32'h10C, 1};
        tbl[4]  = '{0, 1, 0, 0, 0,            0, 32'h0,   32'h10C, 1};
        tbl[5]  = '{0, 1, 0, 0, 0,            0, 32'h0,   32'h10C, 1};
        tbl[6]  = '{1, 0, 0, 0, 0,            0, 32'h0,   32'h110, 1};
        tbl[7]  = '{1, 0, 0, 0, 0,            1, 32'h110, 32'h114, 1};
        tbl[8]  = '{1, 1, 0, 1, 0,            1, 32'h114, 32'h0,   0};
        tbl[9]  = '{1, 0, 0, 0, 0,            0, 32'h0,   32'h118, 1};
        tbl[10] = '{1, 0, 1, 0, 32'hFFFF_FFFC, 1, 32'h118, 32'h0,   0};
        tbl[11] = '{1, 0, 0, 0, 0,            1, 32'hFFFF_FFFC, 32'h0, 1};
        tbl[12] = '{1, 0, 0, 0, 0,            1, 32'h0,   32'h4,   1};

        rst = 1'b0;
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        chk("req_in_reset", {31'h0, mif.imem_req}, 0);
        @(posedge clk); #1;
        chk("rst_instr", Instruction, NOP);
        chk("rst_next", Next_Address, 0);
        chk("rst_valid", {31'h0, if_valid}, 0);
        chk("rst_err", {31'h0, fetch_err}, 0);
        rst = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].pw, tbl[i].fz, tbl[i].src, tbl[i].ba, tbl[i].fl);
            @(negedge clk);
            chk($sformatf("t%0d_req", i), {31'h0, mif.imem_req}, {31'h0, tbl[i].exp_req});
            if (tbl[i].exp_req) chk($sformatf("t%0d_addr", i), mif.imem_addr, tbl[i].exp_addr);
            @(posedge clk); #1;
            chk($sformatf("t%0d_next", i), Next_Address, tbl[i].exp_next);
            chk($sformatf("t%0d_valid", i), {31'h0, if_valid}, {31'h0, tbl[i].exp_vld});
            chk($sformatf("t%0d_instr", i), Instruction,
                tbl[i].exp_vld ? mem_word(tbl[i].exp_next - 32'd4) : NOP);
        end

        // Redirect while a slow request is outstanding -> DRAIN
        drive(1, 0, 0, 0, 0);
        fixed_lat = 3;
        @(posedge clk); #1;
        chk("prime_next", Next_Address, 32'h8);
        drive(1, 0, 1, 32'h400, 0);
        @(negedge clk);
        chk("drain_req_addr", mif.imem_addr, 32'h8);
        @(posedge clk); #1;
        drive(1, 0, 0, 0, 0);
        chk("drain_bubble", {31'h0, if_valid}, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("drain%0d_req", k), {31'h0, mif.imem_req}, 1);
            chk($sformatf("drain%0d_addr", k), mif.imem_addr, 32'h8);
            @(posedge clk); #1;
            chk($sformatf("drain%0d_vld", k), {31'h0, if_valid}, 0);
        end
        @(negedge clk);
        chk("redir_addr", mif.imem_addr, 32'h400);
        found = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (if_valid) begin found = 1; break; end
        end
        chk("redir_arrive", {31'h0, found}, 1);
        chk("redir_next", Next_Address, 32'h404);
        chk("redir_instr", Instruction, mem_word(32'h400));

        // Misaligned redirect
`ifdef IF_MISALIGN_CHK_EN
        exp_tgt = 32'h400; exp_err = 1'b1;
`else
        exp_tgt = 32'h402; exp_err = 1'b0;
`endif
        fixed_lat = 0;
        drive(1, 0, 1, 32'h402, 0);
        @(posedge clk); #1;
        drive(1, 0, 0, 0, 0);
        chk("mis_err", {31'h0, fetch_err}, {31'h0, exp_err});
        found = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (mif.imem_req && mif.imem_addr == exp_tgt) begin found = 1; break; end
        end
        chk("mis_addr_seen", {31'h0, found}, 1);
        @(posedge clk); #1;
        chk("mis_err_sticky", {31'h0, fetch_err}, {31'h0, exp_err});
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mis_err_clr", {31'h0, fetch_err}, 0);

        // Randomized run against the model
        rand_lat = 1'b1;
        m_addr = RPC; m_pc = RPC; stale = 0; m_err = 0;
        e_instr = NOP; e_next = 0; e_vld = 0;
        for (int i = 0; i < 3000; i++) begin
            r = (i == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
            rst = r;
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 9) == 0);
            st = freeze | ~PCWrite;
            @(negedge clk);
            e_req = r && (held_q.size() == 0);
            chk("rnd_req", {31'h0, mif.imem_req}, {31'h0, e_req});
            if (e_req) chk("rnd_addr", mif.imem_addr, m_addr);
            v = e_req && mif.imem_valid;
            @(posedge clk); #1;
`ifdef IF_MISALIGN_CHK_EN
            tgt = Branch_Address & ~32'd3;
`else
            tgt = Branch_Address;
`endif
            if (!r) begin
                m_addr = RPC; m_pc = RPC; held_q.delete(); stale = 0; m_err = 0;
                e_instr = NOP; e_next = 0; e_vld = 0;
            end else if (PCSrc) begin
`ifdef IF_MISALIGN_CHK_EN
                if (Branch_Address[1:0] != 2'b00) m_err = 1;
`endif
                e_instr = NOP; e_next = 0; e_vld = 0;
                held_q.delete();
                m_pc = tgt;
                if (!stale) begin
                    if (e_req && !v) stale = 1;
                    else m_addr = tgt;
                end
            end else if (stale) begin
                e_instr = NOP; e_next = 0; e_vld = 0;
                if (v) begin stale = 0; m_addr = m_pc; end
            end else if (held_q.size() != 0) begin
                if (flush) begin
                    e_instr = NOP; e_next = 0; e_vld = 0;
                end else if (!st) begin
                    e_instr = held_q.pop_front(); e_next = m_pc; e_vld = 1;
                    m_addr = m_pc;
                end
            end else if (v) begin
                if (st || flush) begin
                    held_q.push_back(mem_word(m_addr));
                    m_pc = m_addr + 32'd4;
                    if (flush) begin e_instr = NOP; e_next = 0; e_vld = 0; end
                end else begin
                    e_instr = mem_word(m_addr); e_next = m_addr + 32'd4; e_vld = 1;
                    m_addr = m_addr + 32'd4;
                end
            end else if (flush || !st) begin
                e_instr = NOP; e_next = 0; e_vld = 0;
            end
            chk("rnd_instr", Instruction, e_instr);
            chk("rnd_next", Next_Address, e_next);
            chk("rnd_valid", {31'h0, if_valid}, {31'h0, e_vld});
            chk("rnd_err", {31'h0, fetch_err}, {31'h0, m_err});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the 32-bit five-stage pipeline, directly upstream of the decode stage. It owns the program counter and drives a single-outstanding request/valid handshake to instruction memory. It also owns the IF/ID pipeline register that feeds `Instruction` and `Next_Address` into decode. It obeys the decode stage's `PCWrite`/`freeze` stall, `PCSrc`/`Branch_Address` redirect and `flush` squash.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded at reset
- `NOP_INSTR`, 32'h0000_0000, bubble instruction written into IF/ID
- `clk` in 1, single clock, all state on rising edge
- `rst` in 1, reset; synchronous, active-low
- `PCWrite` in 1, 1 = PC may advance (from hazard detector)
- `freeze` in 1, 1 = hold IF/ID contents (from hazard detector)
- `PCSrc` in 1, 1 = redirect fetch to `Branch_Address`
- `Branch_Address` in 32, redirect target
- `flush` in 1, 1 = load bubble into IF/ID
- `imem_req` out 1, fetch request
- `imem_addr` out 32, fetch address
- `imem_rdata` in 32, fetched word
- `imem_valid` in 1, `imem_rdata` valid; may rise in the same cycle as `imem_req`
- `Instruction` out 32, IF/ID instruction
- `Next_Address` out 32, IF/ID PC+4 of that instruction
- `if_valid` out 1, IF/ID holds a real instruction
- `fetch_err` out 1, sticky misaligned-redirect flag (see Configuration)

## Operation
- `stall` = `freeze` | ~`PCWrite`.
- Registers:
  - `pc`: next address to fetch.
  - `req_addr`: drives `imem_addr` and is stable while a request is outstanding.
  - 32-bit `hold_buf`.
  - IF/ID register.
  - FSM.
- `imem_req` = (state == FETCH or DRAIN) & `rst`.
- Priority at each edge: reset > `PCSrc` > `flush` > `stall`.
- FETCH:
  - Valid & ~stall & no redirect/flush: IF/ID <= {`imem_rdata`, `req_addr`+4, valid=1}; `pc`,`req_addr` <= `req_addr`+4.
  - Valid & (stall | flush): word goes to `hold_buf`; go to HOLD; `pc` <= `req_addr`+4.
  - No valid & ~stall: IF/ID <= bubble.
- HOLD: `imem_req`=0. When ~stall & ~flush: IF/ID <= {`hold_buf`, `pc`, valid=1}; `req_addr` <= `pc`; go to FETCH.
- DRAIN: wrong-path request still outstanding. `imem_req` stays 1 with old `req_addr`. On `imem_valid`, discard the data, `req_addr` <= `pc`, go to FETCH.
- `PCSrc`=1 in any state:
  - `pc` <= `Branch_Address`; IF/ID <= bubble; `hold_buf` discarded.
  - FETCH without valid: go to DRAIN.
  - FETCH with valid, or HOLD: `req_addr` <= `Branch_Address`, go to FETCH.
  - DRAIN: stay in DRAIN, retarget `pc`.
- `flush`=1, `PCSrc`=0: IF/ID <= bubble (overrides `stall`); fetch side follows the rules above.
- Bubble = {`NOP_INSTR`, 32'h0, `if_valid`=0}.
- All additions are 32-bit, modulo 2^32; PC wraps 32'hFFFF_FFFC -> 0.

## Timing
- Reset (`rst`=0 at edge): `pc`=`req_addr`=`RESET_PC`, state FETCH, `Instruction`=`NOP_INSTR`, `Next_Address`=0, `if_valid`=0, `fetch_err`=0.
- `imem_req`=0 combinationally while `rst`=0.
- First request is driven in the cycle `rst` is sampled high.
- Zero-wait memory: one instruction per cycle; the IF/ID output appears the edge after `imem_valid`.
- Redirect latency: the first target instruction is in IF/ID 1 cycle after `PCSrc` (zero-wait, no DRAIN). Add the remaining latency of the outstanding request when DRAIN is entered.
- Reset mid-request aborts it. The memory must tolerate `imem_req` dropping before valid.
- Only one request outstanding at any time.

## Configuration
- `IF_MISALIGN_CHK_EN` defined:
  - A redirect with `Branch_Address[1:0]`≠0 sets `fetch_err` (sticky until reset).
  - The low two bits are forced to 00 in `pc`/`req_addr`.
- `IF_MISALIGN_CHK_EN` undefined: `fetch_err` tied 0; the address passes unmodified.

## Structure
- Shared package `pipe_pkg`: `NOP_INSTR` value, word size constant 4, fetch-state enum {FETCH, HOLD, DRAIN}.
- One sub-module `IF2ID`: IF/ID register with load, bubble and hold controls, mirroring the existing inter-stage registers.
- FSM and PC logic stay in `if_fetch_stage`.

## Test plan
- Reset with `RESET_PC`=0x100, zero-wait memory returning addr-derived words -> `imem_addr` 0x100,0x104,0x108 on consecutive cycles; `Next_Address` 0x104,0x108,0x10C; `if_valid`=1 from cycle 2.
- Response arrives with `freeze`=1, `PCWrite`=0 for 3 cycles -> IF/ID unchanged, `imem_req`=0; on release the held word appears at the next edge with no refetch.
- `PCSrc`=1, `Branch_Address`=0x400, memory latency 3, request outstanding -> DRAIN; stale word discarded; next `imem_addr`=0x400; IF/ID bubble until the 0x400 word arrives.
- `flush`=1 alone while `freeze`=1 -> IF/ID = `NOP_INSTR`, `if_valid`=0; the concurrent response is delivered the next cycle.
- `pc`=0xFFFF_FFFC fetched -> `Next_Address`=0x0, next `imem_addr`=0x0.
- With `IF_MISALIGN_CHK_EN`: redirect to 0x402 -> `imem_addr`=0x400, `fetch_err`=1 and stays set until `rst`=0.
